// File: rtl/id_inst_queue.sv
// Instruction queue between fetch SRAM return and decode: splits 64-bit fetch words into
// 32-bit instructions. Optional same-cycle bypass when empty: define ID_INST_QUEUE_BYPASS_EN.
module id_inst_queue #(
   parameter int DEPTH = 8,
   parameter int PC_W  = 64,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [PC_W-1:0]  in_pc,
   input  logic [63:0]      in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [PC_W-1:0]  out_pc,
   output logic [31:0]      out_inst,
   output logic [CNT_W-1:0] count
);

   localparam int AW = CNT_W - 1;
   localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - 2);

   logic [PC_W-1:0]  mem_pc_q   [DEPTH];
   logic [31:0]      mem_inst_q [DEPTH];
   logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;

   logic             empty, push, pop, bypass, rd_adv, two_half;
   logic [PC_W-1:0]  first_pc, second_pc, head_pc, wpc0;
   logic [31:0]      first_inst, second_inst, head_inst, winst0;
   logic             we0, we1;
   logic [1:0]       n_write;
   logic [AW-1:0]    wr_idx0, wr_idx1;

   assign count    = wr_ptr_q - rd_ptr_q;
   assign empty    = (wr_ptr_q == rd_ptr_q);
   // Registered count only, so a two-entry push always fits and in_ready never sees out_ready.
   assign in_ready = (count <= READY_MAX);
   assign push     = in_valid & in_ready & ~flush;

   assign two_half    = ~in_pc[2];
   assign first_pc    = in_pc;
   assign first_inst  = in_pc[2] ? in_data[63:32] : in_data[31:0];
   assign second_pc   = in_pc + PC_W'(4);
   assign second_inst = in_data[63:32];

`ifdef ID_INST_QUEUE_BYPASS_EN
   assign bypass = empty & push;
`else
   assign bypass = 1'b0;
`endif

   assign out_valid = (~empty | bypass) & ~flush;
   assign pop       = out_valid & out_ready;
   assign rd_adv    = pop & ~bypass;
   assign head_pc   = bypass ? first_pc   : mem_pc_q[rd_ptr_q[AW-1:0]];
   assign head_inst = bypass ? first_inst : mem_inst_q[rd_ptr_q[AW-1:0]];
   assign out_pc    = out_valid ? head_pc   : '0;
   assign out_inst  = out_valid ? head_inst : '0;

   assign wr_idx0 = wr_ptr_q[AW-1:0];
   assign wr_idx1 = wr_idx0 + AW'(1);

   always_comb begin
      we0     = 1'b0;
      we1     = 1'b0;
      wpc0    = first_pc;
      winst0  = first_inst;
      n_write = 2'd0;
      if (push) begin
         if (bypass && out_ready) begin
            // First instruction went straight to decode; only the upper half is kept.
            if (two_half) begin
               we0     = 1'b1;
               wpc0    = second_pc;
               winst0  = second_inst;
               n_write = 2'd1;
            end
         end else begin
            we0     = 1'b1;
            n_write = 2'd1;
            if (two_half) begin
               we1     = 1'b1;
               n_write = 2'd2;
            end
         end
      end
   end

   always_comb begin
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         wr_ptr_d = wr_ptr_q + CNT_W'(n_write);
         rd_ptr_d = rd_ptr_q + CNT_W'(rd_adv);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (we0) begin
         mem_pc_q[wr_idx0]   <= wpc0;
         mem_inst_q[wr_idx0] <= winst0;
      end
      if (we1) begin
         mem_pc_q[wr_idx1]   <= second_pc;
         mem_inst_q[wr_idx1] <= second_inst;
      end
   end

endmodule

// File: tb/tb_id_inst_queue.sv
// Bench for id_inst_queue: directed scenarios plus random traffic against a queue-level model.
module tb_id_inst_queue;

   localparam int DEPTH = 8;
`ifdef ID_INST_QUEUE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] in_pc = '0;
   logic [63:0] in_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] out_pc;
   logic [31:0] out_inst;
   logic [3:0]  count;

   int n_checks = 0;
   int n_fail   = 0;

   // Each entry is {pc[63:0], inst[31:0]}, head at index 0.
   logic [95:0] exp_q[$];

   id_inst_queue #(.DEPTH(DEPTH), .PC_W(64)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
      .count(count)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [63:0] pc, input logic [63:0] data,
                        input logic rdy, input logic fl);
      in_valid  = v;
      in_pc     = pc;
      in_data   = data;
      out_ready = rdy;
      flush     = fl;
   endtask

   task automatic idle();
      drive(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
      #1;
   endtask

   // What decode and fetch should see right now, from queue contents and current inputs.
   task automatic model_eval(output bit m_valid, output bit m_ready, output bit m_push,
                             output logic [95:0] m_head);
      int sz;
      logic [31:0] lead;
      sz      = exp_q.size();
      m_ready = (DEPTH - sz) >= 2;
      m_push  = in_valid && m_ready && !flush;
      m_valid = !flush && (sz > 0 || (BYP && m_push));
      lead    = in_pc[2] ? in_data[63:32] : in_data[31:0];
      m_head  = (sz > 0) ? exp_q[0] : {in_pc, lead};
   endtask

   task automatic check_model(input string tag);
      bit m_valid, m_ready, m_push;
      logic [95:0] m_head;
      model_eval(m_valid, m_ready, m_push, m_head);
      check({tag, ".out_valid"}, 64'(out_valid), 64'(m_valid));
      check({tag, ".in_ready"}, 64'(in_ready), 64'(m_ready));
      check({tag, ".count"}, 64'(count), 64'(exp_q.size()));
      check({tag, ".out_pc"}, out_pc, m_valid ? m_head[95:32] : 64'h0);
      check({tag, ".out_inst"}, 64'(out_inst), m_valid ? 64'(m_head[31:0]) : 64'h0);
   endtask

   task automatic edge_update();
      bit m_valid, m_ready, m_push;
      logic [95:0] m_head;
      model_eval(m_valid, m_ready, m_push, m_head);
      @(posedge clk);
      if (flush) begin
         exp_q.delete();
      end else begin
         if (m_push) begin
            exp_q.push_back({in_pc, in_pc[2] ? in_data[63:32] : in_data[31:0]});
            if (!in_pc[2]) exp_q.push_back({in_pc + 64'd4, in_data[63:32]});
         end
         if (m_valid && out_ready) void'(exp_q.pop_front());
      end
      #1;
   endtask

   task automatic step(input string tag, input logic v, input logic [63:0] pc,
                       input logic [63:0] data, input logic rdy, input logic fl);
      drive(v, pc, data, rdy, fl);
      @(negedge clk);
      check_model(tag);
      edge_update();
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom(), $urandom()};
   endfunction

   initial begin
      #3;
      check("rst.out_valid", 64'(out_valid), 64'h0);
      check("rst.out_pc", out_pc, 64'h0);
      check("rst.out_inst", 64'(out_inst), 64'h0);
      check("rst.count", 64'(count), 64'h0);
      check("rst.in_ready", 64'(in_ready), 64'h1);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Basic two-instruction word, decode ready.
      step("t1.push", 1'b1, 64'h8000_0000, 64'h00500093_00100013, 1'b1, 1'b0);
`ifndef ID_INST_QUEUE_BYPASS_EN
      idle();
      check("t1.pc0", out_pc, 64'h8000_0000);
      check("t1.inst0", 64'(out_inst), 64'h00100013);
      step("t1.pop0", 1'b0, 64'h0, 64'h0, 1'b1, 1'b0);
`endif
      idle();
      check("t1.pc1", out_pc, 64'h8000_0004);
      check("t1.inst1", 64'(out_inst), 64'h00500093);
      step("t1.pop1", 1'b0, 64'h0, 64'h0, 1'b1, 1'b0);
      idle();
      check("t1.empty_valid", 64'(out_valid), 64'h0);
      check("t1.empty_count", 64'(count), 64'h0);

      // Same-cycle visibility on an empty queue depends on the bypass build.
      drive(1'b1, 64'h8000_1000, 64'hAAAA_0001_BBBB_0002, 1'b1, 1'b0);
      #1;
      check("byp.same_valid", 64'(out_valid), BYP ? 64'h1 : 64'h0);
      check("byp.same_inst", 64'(out_inst), BYP ? 64'hBBBB_0002 : 64'h0);
      @(negedge clk);
      check_model("byp");
      edge_update();
      idle();
      check("byp.count", 64'(count), BYP ? 64'h1 : 64'h2);
      while (exp_q.size() > 0) step("byp.drain", 1'b0, 64'h0, 64'h0, 1'b1, 1'b0);

      // Odd-half word yields exactly one entry.
      step("t2.push", 1'b1, 64'h8000_0004, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0);
      idle();
      check("t2.count", 64'(count), 64'h1);
      check("t2.inst", 64'(out_inst), 64'h1234_5678);
      check("t2.pc", out_pc, 64'h8000_0004);
      step("t2.drain", 1'b0, 64'h0, 64'h0, 1'b1, 1'b0);

      // Fill to full under decode stall, then drain in PC order.
      for (int i = 0; i < 4; i++)
         step("t3.fill", 1'b1, 64'h2000 + 64'(8 * i), rnd64(), 1'b0, 1'b0);
      idle();
      check("t3.count_full", 64'(count), 64'h8);
      check("t3.in_ready_full", 64'(in_ready), 64'h0);
      for (int i = 0; i < 8; i++) begin
         idle();
         check("t3.drain_pc", out_pc, 64'h2000 + 64'(4 * i));
         step("t3.drain", 1'b0, 64'h0, 64'h0, 1'b1, 1'b0);
      end
      idle();
      check("t3.count_empty", 64'(count), 64'h0);

      // Seven entries: in_ready already low, including when a pop happens this cycle.
      for (int i = 0; i < 3; i++)
         step("t4.fill", 1'b1, 64'h3000 + 64'(8 * i), rnd64(), 1'b0, 1'b0);
      step("t4.single", 1'b1, 64'h3104, rnd64(), 1'b0, 1'b0);
      idle();
      check("t4.count7", 64'(count), 64'h7);
      check("t4.ready7", 64'(in_ready), 64'h0);
      step("t4.blocked", 1'b1, 64'h3200, rnd64(), 1'b0, 1'b0);
      step("t4.pop_push", 1'b1, 64'h3300, rnd64(), 1'b1, 1'b0);
      idle();
      check("t4.count6", 64'(count), 64'h6);

      // Flush with push and pop requested in the same cycle.
      drive(1'b1, 64'h4000, rnd64(), 1'b1, 1'b1);
      #1;
      check("t5.flush_valid", 64'(out_valid), 64'h0);
      check("t5.flush_pc", out_pc, 64'h0);
      @(negedge clk);
      check_model("t5");
      edge_update();
      idle();
      check("t5.count", 64'(count), 64'h0);
      check("t5.valid", 64'(out_valid), 64'h0);
      step("t5.after", 1'b0, 64'h0, 64'h0, 1'b1, 1'b0);

      // Random traffic with one asynchronous reset in the middle.
      for (int i = 0; i < 1000; i++) begin
         if (i == 500) begin
            idle();
            rst = 1'b1;
            #1;
            check("rnd.rst_count", 64'(count), 64'h0);
            check("rnd.rst_valid", 64'(out_valid), 64'h0);
            check("rnd.rst_ready", 64'(in_ready), 64'h1);
            rst = 1'b0;
            exp_q.delete();
         end
         step("rnd",
              $urandom_range(0, 99) < 70,
              {32'h8000_0000, 20'h0, 10'($urandom_range(0, 1023)), 2'b00},
              rnd64(),
              $urandom_range(0, 99) < 45,
              $urandom_range(0, 99) < 3);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/id_inst_queue.md
# id_inst_queue

Parametrised instruction queue between the fetch SRAM return and the decode stage. It replaces the single-entry stall capture register with a DEPTH-entry FIFO. Each 64-bit fetch word is split into one or two 32-bit instructions with their PCs, and the queue presents one instruction per cycle to decode over a valid/ready handshake. A branch flush discards all buffered instructions in one cycle, and decode stalls no longer lose in-flight fetch data.

## Interface
- DEPTH, 8: number of instruction entries; power of two, at least 4.
- PC_W, 64: PC width.
- CNT_W, $clog2(DEPTH)+1: width of the occupancy count; derived, not overridden.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  branch or exception redirect; empties the queue.
- in_valid  in  1  fetch word on in_data is valid.
- in_ready  out  1  queue accepts a fetch word this cycle.
- in_pc  in  PC_W  PC of the fetch request; bit 1 and bit 0 are ignored.
- in_data  in  64  fetch word; [31:0] is the instruction at PC with pc[2]=0, [63:32] is the instruction at PC with pc[2]=1.
- out_valid  out  1  out_pc and out_inst hold an instruction.
- out_ready  in  1  decode consumes the instruction (low = decode stall).
- out_pc  out  PC_W  PC of the head instruction; 0 when out_valid=0.
- out_inst  out  32  head instruction; 0 when out_valid=0.
- count  out  CNT_W  current number of stored entries.

## Operation
- Storage is an array of DEPTH entries of {pc, inst}.
- Read and write pointers are CNT_W bits wide: the low bits index the array and the MSB is the wrap bit.
- Empty: pointers are equal. Full: low bits are equal and the MSBs differ.
- Push occurs when in_valid & in_ready & !flush:
  - in_pc[2]=0: two entries are written, {in_pc, in_data[31:0]} then {in_pc+4, in_data[63:32]}.
  - in_pc[2]=1: one entry is written, {in_pc, in_data[63:32]}.
- in_ready = (DEPTH - count) >= 2, evaluated combinationally from the registered count. This ensures a two-entry push always fits.
- Pop occurs when out_valid & out_ready. The read pointer advances by 1.
- count_next = count + pushed - popped, where pushed is 0, 1 or 2 and popped is 0 or 1. A push and a pop in the same cycle are legal at any occupancy.
- While flush=1:
  - out_valid is forced to 0, so out_pc and out_inst read 0.
  - The push is ignored.
  - At the next edge both pointers and count are set to 0.
- flush has priority over push and pop in the same cycle.
- out_pc and out_inst are masked with out_valid, so decode sees a bubble as all-zero fields (inst 0 decodes as a no-op with rf_we=0).

## Timing
- Reset values: out_valid=0, out_pc=0, out_inst=0, count=0, in_ready=1, both pointers 0. Array contents are don't-care.
- Base latency: an instruction pushed at edge N appears on out_* in the cycle after edge N.
- An asserted rst overrides everything, including mid-push and mid-flush; state returns to reset values asynchronously.
- Wrap-around: pointers roll past DEPTH-1 to index 0 with the wrap bit toggled. A two-entry push may straddle the wrap boundary.
- When in_ready=0, in_data is not sampled. The fetch side holds or re-requests the word; the queue does not capture it.
- A pop and a push at full-minus-one: in_ready is already 0 because it is based on the registered count, not the post-pop count. This is intentional and keeps in_ready free of out_ready.

## Configuration
- ID_INST_QUEUE_BYPASS_EN defined:
  - When the queue is empty and a push occurs, the first pushed instruction is driven on out_* in the same cycle (combinational path from in_pc/in_data).
  - If out_ready=1 in that cycle, that instruction is not written. Only the second half, if any, is stored.
  - If out_ready=0, both instructions are stored normally.
  - Zero-cycle latency when empty.
- Not defined: no combinational path from in_* to out_*. Base latency is one cycle in all cases.

## Test plan
- Reset, then push in_pc=0x80000000, in_data=0x00500093_00100013, out_ready=1.
  - Next cycle: out_pc=0x80000000, out_inst=0x00100013.
  - Following cycle: out_pc=0x80000004, out_inst=0x00500093, then out_valid=0.
- Push with in_pc=0x80000004 (pc[2]=1): exactly one entry appears, out_inst=in_data[63:32], count=1.
- Hold out_ready=0 with DEPTH=8 and push four pc[2]=0 words: count reaches 8 and in_ready=0 from count=7 onward. Release out_ready: eight instructions drain in PC order with no loss or duplication.
- Fill to 6 entries, assert flush together with in_valid=1 and out_ready=1:
  - In the flush cycle, out_valid=0.
  - Next cycle: count=0, out_valid=0, and the flushed-cycle word is absent.
- Run 1000 random push/pop/flush cycles against a reference model. Check PC ordering across pointer wrap, count accuracy, and that in_ready never permits overflow.
- With ID_INST_QUEUE_BYPASS_EN, empty queue, push pc[2]=0 with out_ready=1: out_valid=1 in the same cycle with the low instruction, and count=1 next cycle. Without the macro, out_valid stays 0 in that cycle.
